// File: rtl/sobeob_pkg.sv
// Shared definitions for the SOB/EOB broadcast: command codes, decoder states
// and error-flag bit positions. The dispatcher encodes with the same constants.
package sobeob_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_BAD  = 2'b01;
  localparam logic [1:0] CMD_EOB  = 2'b10;
  localparam logic [1:0] CMD_SOB  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ERR_BITS     = 4;
  localparam int ERR_EOB_IDLE = 0;
  localparam int ERR_SOB_RUN  = 1;
  localparam int ERR_BAD      = 2;
  localparam int ERR_TS_SAT   = 3;

  // A code acts once: it must be non-idle and differ from the code before it.
  function automatic logic isNewCmd(input logic [1:0] cmdQ, input logic [1:0] cmdQq);
    return (cmdQ != CMD_NONE) && (cmdQ != cmdQq);
  endfunction

endpackage

// File: rtl/sobeob_cmd_decode.sv
// Two-stage capture of the {ECRST,BCRST} pair with change detection, producing
// one-hot single-cycle SOB/EOB/BAD command indications.
module sobeob_cmd_decode
  import sobeob_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_ecrst,
  input  logic i_bcrst,
  output logic o_isSob,
  output logic o_isEob,
  output logic o_isBad
);

  logic [1:0] r_cmdQ;
  logic [1:0] r_cmdQq;
  logic       w_newCmd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmdQ  <= CMD_NONE;
      r_cmdQq <= CMD_NONE;
    end else begin
      r_cmdQ  <= {i_ecrst, i_bcrst};
      r_cmdQq <= r_cmdQ;
    end
  end

  assign w_newCmd = isNewCmd(r_cmdQ, r_cmdQq);
  assign o_isSob  = w_newCmd && (r_cmdQ == CMD_SOB);
  assign o_isEob  = w_newCmd && (r_cmdQ == CMD_EOB);
  assign o_isBad  = w_newCmd && (r_cmdQ == CMD_BAD);

endmodule

// File: rtl/sobeob_decoder.sv
// Receive-side SOB/EOB decoder: rebuilds burst level, strobes, in-burst
// timestamp, burst counter and EOB length, and flags protocol violations.
module sobeob_decoder
  import sobeob_pkg::*;
#(
  parameter int TS_WIDTH  = 32,
  parameter int BID_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ECRST,
  input  logic                 BCRST,
  input  logic                 ERR_CLR,
  output logic                 BURST,
  output logic                 SOB_PULSE,
  output logic                 EOB_PULSE,
  output logic [TS_WIDTH-1:0]  TIMESTAMP,
  output logic [BID_WIDTH-1:0] BURST_ID,
  output logic [TS_WIDTH-1:0]  EOB_TS,
  output logic [ERR_BITS-1:0]  ERR_FLAGS
);

  localparam logic [TS_WIDTH-1:0]  TS_ONE  = 1;
  localparam logic [BID_WIDTH-1:0] BID_ONE = 1;

  logic w_isSob;
  logic w_isEob;
  logic w_isBad;

  state_t r_state;
  state_t w_nextState;

  logic                 r_burst;
  logic                 r_sobPulse;
  logic                 r_eobPulse;
  logic [TS_WIDTH-1:0]  r_timestamp;
  logic [BID_WIDTH-1:0] r_burstId;
  logic [TS_WIDTH-1:0]  r_eobTs;
  logic [ERR_BITS-1:0]  r_err;

  logic                w_sobSet;
  logic                w_eobSet;
  logic                w_tsRestart;
  logic                w_tsAdvance;
  logic                w_tsMax;
  logic [ERR_BITS-1:0] w_errSet;

  sobeob_cmd_decode u_cmdDecode (
    .clk     (clk),
    .reset   (reset),
    .i_ecrst (ECRST),
    .i_bcrst (BCRST),
    .o_isSob (w_isSob),
    .o_isEob (w_isEob),
    .o_isBad (w_isBad)
  );

  assign w_tsMax = &r_timestamp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A repeated SOB inside a burst restarts it rather than being dropped.
  always_comb begin
    w_nextState = r_state;
    w_sobSet    = 1'b0;
    w_eobSet    = 1'b0;
    w_tsRestart = 1'b0;
    w_tsAdvance = 1'b0;
    w_errSet    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_isSob) begin
          w_nextState = RUN;
          w_sobSet    = 1'b1;
          w_tsRestart = 1'b1;
        end else if (w_isEob) begin
          w_errSet[ERR_EOB_IDLE] = 1'b1;
        end
      end
      RUN: begin
        if (w_isSob) begin
          w_errSet[ERR_SOB_RUN] = 1'b1;
          w_sobSet              = 1'b1;
          w_tsRestart           = 1'b1;
        end else begin
          w_tsAdvance = 1'b1;
          if (w_isEob) begin
            w_nextState = IDLE;
            w_eobSet    = 1'b1;
          end
        end
      end
    endcase
    if (w_isBad) begin
      w_errSet[ERR_BAD] = 1'b1;
    end
    if (w_tsAdvance && w_tsMax) begin
      w_errSet[ERR_TS_SAT] = 1'b1;
    end
  end

  // EOB_TS captures the count before this edge's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst     <= 1'b0;
      r_sobPulse  <= 1'b0;
      r_eobPulse  <= 1'b0;
      r_timestamp <= '0;
      r_burstId   <= '0;
      r_eobTs     <= '0;
      r_err       <= '0;
    end else begin
      r_burst    <= (w_nextState == RUN);
      r_sobPulse <= w_sobSet;
      r_eobPulse <= w_eobSet;
      if (w_tsRestart) begin
        r_timestamp <= '0;
      end else if (w_tsAdvance && !w_tsMax) begin
        r_timestamp <= r_timestamp + TS_ONE;
      end
      if (w_sobSet) begin
        r_burstId <= r_burstId + BID_ONE;
      end
      if (w_eobSet) begin
        r_eobTs <= r_timestamp;
      end
      r_err <= (ERR_CLR ? '0 : r_err) | w_errSet;
    end
  end

  assign BURST     = r_burst;
  assign SOB_PULSE = r_sobPulse;
  assign EOB_PULSE = r_eobPulse;
  assign TIMESTAMP = r_timestamp;
  assign BURST_ID  = r_burstId;
  assign EOB_TS    = r_eobTs;
  assign ERR_FLAGS = r_err;

endmodule

// File: tb/tb_sobeob_decoder.sv
// Scoreboard bench for sobeob_decoder: directed scenarios then random command
// traffic, compared cycle by cycle against a behavioural burst model.
module tb_sobeob_decoder;

  localparam int TSW   = 4;
  localparam int BIDW  = 4;
  localparam int TSMAX = (1 << TSW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ECRST = 1'b0;
  logic            BCRST = 1'b0;
  logic            ERR_CLR = 1'b0;
  logic            BURST;
  logic            SOB_PULSE;
  logic            EOB_PULSE;
  logic [TSW-1:0]  TIMESTAMP;
  logic [BIDW-1:0] BURST_ID;
  logic [TSW-1:0]  EOB_TS;
  logic [3:0]      ERR_FLAGS;

  typedef struct {
    logic       burst;
    logic       sob;
    logic       eob;
    logic [3:0] ts;
    logic [3:0] id;
    logic [3:0] eobTs;
    logic [3:0] err;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int         mRun;
  int         mTs;
  int         mId;
  int         mEobTs;
  logic [3:0] mErr;
  logic [1:0] h1;
  logic [1:0] h2;
  logic [1:0] curCode;

  sobeob_decoder #(.TS_WIDTH(TSW), .BID_WIDTH(BIDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ECRST     (ECRST),
    .BCRST     (BCRST),
    .ERR_CLR   (ERR_CLR),
    .BURST     (BURST),
    .SOB_PULSE (SOB_PULSE),
    .EOB_PULSE (EOB_PULSE),
    .TIMESTAMP (TIMESTAMP),
    .BURST_ID  (BURST_ID),
    .EOB_TS    (EOB_TS),
    .ERR_FLAGS (ERR_FLAGS)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Drive one cycle of input; the model advances by the command from one step earlier.
  task automatic applyStimulus(input logic [1:0] code, input logic clr);
    logic [1:0] ev;
    logic [3:0] newErr;
    int         tsOld;
    logic       sobP;
    logic       eobP;
    @(negedge clk);
    {ECRST, BCRST} = code;
    ERR_CLR = clr;
    ev = (h1 != 2'b00 && h1 != h2) ? h1 : 2'b00;
    newErr = 4'b0000;
    sobP = 1'b0;
    eobP = 1'b0;
    tsOld = mTs;
    if (mRun != 0 && ev != 2'b11) begin
      if (tsOld == TSMAX) newErr[3] = 1'b1;
      else mTs = tsOld + 1;
    end
    case (ev)
      2'b11: begin
        if (mRun != 0) newErr[1] = 1'b1;
        mRun = 1;
        mTs = 0;
        mId = (mId + 1) % (1 << BIDW);
        sobP = 1'b1;
      end
      2'b10: begin
        if (mRun == 0) newErr[0] = 1'b1;
        else begin
          mEobTs = tsOld;
          mRun = 0;
          eobP = 1'b1;
        end
      end
      2'b01: newErr[2] = 1'b1;
      default: ;
    endcase
    mErr = (clr ? 4'b0000 : mErr) | newErr;
    q.push_back('{(mRun != 0), sobP, eobP, 4'(mTs), 4'(mId), 4'(mEobTs), mErr});
    h2 = h1;
    h1 = code;
  endtask

  task automatic resetDut();
    @(negedge clk);
    ECRST = 1'b0;
    BCRST = 1'b0;
    ERR_CLR = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_burst", 32'(BURST), 0);
    checkOutput("rst_sob", 32'(SOB_PULSE), 0);
    checkOutput("rst_eob", 32'(EOB_PULSE), 0);
    checkOutput("rst_ts", 32'(TIMESTAMP), 0);
    checkOutput("rst_id", 32'(BURST_ID), 0);
    checkOutput("rst_eobts", 32'(EOB_TS), 0);
    checkOutput("rst_err", 32'(ERR_FLAGS), 0);
    mRun = 0;
    mTs = 0;
    mId = 0;
    mEobTs = 0;
    mErr = 4'b0000;
    h1 = 2'b00;
    h2 = 2'b00;
    curCode = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every post-edge sample is checked against the oldest queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      checkOutput("burst", 32'(BURST), 32'(e.burst));
      checkOutput("sob_pulse", 32'(SOB_PULSE), 32'(e.sob));
      checkOutput("eob_pulse", 32'(EOB_PULSE), 32'(e.eob));
      checkOutput("timestamp", 32'(TIMESTAMP), 32'(e.ts));
      checkOutput("burst_id", 32'(BURST_ID), 32'(e.id));
      checkOutput("eob_ts", 32'(EOB_TS), 32'(e.eobTs));
      checkOutput("err_flags", 32'(ERR_FLAGS), 32'(e.err));
      checkOutput("pulse_excl", 32'(SOB_PULSE & EOB_PULSE), 0);
    end
  end

  initial begin
    int r;
    resetDut();

    applyStimulus(2'b11, 1'b0);
    repeat (9) applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0);

    applyStimulus(2'b10, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b00, 1'b1);
    applyStimulus(2'b00, 1'b0);

    applyStimulus(2'b11, 1'b0);
    repeat (4) applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0);

    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b00, 1'b1);
    repeat (4) applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b01, 1'b0);
    repeat (2) applyStimulus(2'b00, 1'b0);

    repeat (20) applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0);
    repeat (2) applyStimulus(2'b00, 1'b0);

    applyStimulus(2'b11, 1'b0);
    repeat (8) applyStimulus(2'b00, 1'b0);
    resetDut();
    applyStimulus(2'b11, 1'b0);
    repeat (3) applyStimulus(2'b00, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        resetDut();
      end
      if ($urandom_range(0, 9) >= 6) begin
        r = $urandom_range(0, 9);
        if (r < 5) curCode = 2'b00;
        else if (r < 7) curCode = 2'b11;
        else if (r < 9) curCode = 2'b10;
        else curCode = 2'b01;
      end
      applyStimulus(curCode, ($urandom_range(0, 15) == 0));
    end

    repeat (3) applyStimulus(2'b00, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
